// File: rtl/led_fader_pkg.sv
// Shared constants and types for the LED fader: default geometry, level range and level vector type.
package led_fader_pkg;

  localparam int unsigned DEF_NUM_LEDS = 10;
  localparam int unsigned DEF_PWM_BITS = 8;
  localparam int unsigned DEF_PRESCALE = 196;
  localparam int unsigned DEF_STEP     = 4;

  // Full-on brightness code for a PWM counter of the given width.
  function automatic int unsigned level_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  typedef logic [DEF_PWM_BITS-1:0] level_t;
  typedef level_t [DEF_NUM_LEDS-1:0] level_vec_t;

endpackage

// File: rtl/led_fader_channel.sv
// One LED: brightness level with saturating fade steps, PWM compare and target-mismatch flag.
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEF_PWM_BITS,
  parameter int unsigned STEP     = DEF_STEP
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                target_i,
  input  logic                period_end_i,
  input  logic                fade_enable_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o,
  output logic                mismatch_c
);

  localparam int unsigned LW = PWM_BITS + 1;
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(level_max(PWM_BITS));
  localparam logic [LW-1:0]       STEP_W    = LW'(STEP);

  logic [PWM_BITS-1:0] level_q, level_d, target_c;
  logic [LW-1:0]       up_sum, dn_diff;
  logic                led_q, led_d;

  // Next level: snap when not fading, otherwise one saturating step per PWM period.
  always_comb begin
    target_c = target_i ? LEVEL_MAX : '0;
    up_sum   = {1'b0, level_q} + STEP_W;
    dn_diff  = {1'b0, level_q} - STEP_W;
    level_d  = level_q;
    if (!fade_enable_i) begin
      level_d = target_c;
    end else if (period_end_i) begin
      if (level_q < target_c) begin
        level_d = (up_sum > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : up_sum[PWM_BITS-1:0];
      end else if (level_q > target_c) begin
        // Borrow out of the extra bit means the step went below zero.
        level_d = dn_diff[PWM_BITS] ? '0 : dn_diff[PWM_BITS-1:0];
      end
    end
    led_d      = (level_q == LEVEL_MAX) || (level_q > pwm_cnt_i);
    mismatch_c = (level_q != target_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/nios_hps_system_led_fader.sv
// LED fader between the Nios LED PIO and the board pins: shared prescaler/PWM counter, per-LED fade channels.
// Optional LED_FADER_SYNC_EN adds a 2-flop synchroniser on led_pattern and fade_enable.
module nios_hps_system_led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned NUM_LEDS = DEF_NUM_LEDS,
  parameter int unsigned PWM_BITS = DEF_PWM_BITS,
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned STEP     = DEF_STEP
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_pattern,
  input  logic                fade_enable,
  output logic [NUM_LEDS-1:0] leds,
  output logic                busy
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? 32'($clog2(PRESCALE)) : 1;
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(level_max(PWM_BITS));

  logic [CNT_W-1:0]    presc_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic                tick_c, period_end_c;
  logic [NUM_LEDS-1:0] pattern_s, mismatch_c;
  logic                fade_s, busy_q;

`ifdef LED_FADER_SYNC_EN
  logic [NUM_LEDS:0] sync1_q, sync2_q;

  // Two-stage synchroniser for a PIO running in another clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {fade_enable, led_pattern};
      sync2_q <= sync1_q;
    end
  end

  assign {fade_s, pattern_s} = sync2_q;
`else
  assign pattern_s = led_pattern;
  assign fade_s    = fade_enable;
`endif

  assign tick_c       = (presc_q == CNT_W'(PRESCALE - 1));
  assign period_end_c = tick_c && (pwm_q == LEVEL_MAX);

  // Free-running prescaler and PWM counter, independent of pattern activity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      pwm_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      presc_q <= tick_c ? '0 : presc_q + CNT_W'(1);
      if (tick_c) begin
        pwm_q <= pwm_q + PWM_BITS'(1);
      end
      busy_q <= |mismatch_c;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fader_channel #(
      .PWM_BITS(PWM_BITS),
      .STEP    (STEP)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .target_i     (pattern_s[i]),
      .period_end_i (period_end_c),
      .fade_enable_i(fade_s),
      .pwm_cnt_i    (pwm_q),
      .led_o        (leds[i]),
      .mismatch_c   (mismatch_c[i])
    );
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_nios_hps_system_led_fader.sv
// Directed bench for the LED fader: STEP=64 and STEP=100 instances, PRESCALE=1, duty measured per PWM period.
module tb_nios_hps_system_led_fader;
  import led_fader_pkg::*;

  localparam int unsigned N = 10;
`ifdef LED_FADER_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = 2 + SYNC;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] led_pattern = '0;
  logic         fade_enable = 1'b0;
  logic [N-1:0] leds, leds2;
  logic         busy, busy2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [N-1:0] pat;
    logic         busy_mid;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  nios_hps_system_led_fader #(.NUM_LEDS(N), .PWM_BITS(8), .PRESCALE(1), .STEP(64)) dut (
    .clk(clk), .reset_n(reset_n), .led_pattern(led_pattern), .fade_enable(fade_enable),
    .leds(leds), .busy(busy));

  nios_hps_system_led_fader #(.NUM_LEDS(N), .PWM_BITS(8), .PRESCALE(1), .STEP(100)) dut2 (
    .clk(clk), .reset_n(reset_n), .led_pattern(led_pattern), .fade_enable(fade_enable),
    .leds(leds2), .busy(busy2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset(input logic [N-1:0] pat, input logic fade);
    reset_n     = 1'b0;
    led_pattern = pat;
    fade_enable = fade;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic measure(input int n, input logic [N-1:0] mask,
                         inout int on0, inout int bsy, inout int on2, inout int other);
    for (int k = 0; k < n; k++) begin
      tick();
      on0 += int'(leds[0]);
      bsy += int'(busy);
      on2 += int'(leds2[0]);
      if (leds != (leds[0] ? mask : '0)) other++;
    end
  endtask

  // One full PWM period starting at a period boundary; exp_busy < 0 skips the busy check.
  task automatic window(input string name, input int e_on0, input int e_busy, input int e_on2,
                        input logic [N-1:0] mask);
    int on0 = 0, bsy = 0, on2 = 0, other = 0;
    measure(256, mask, on0, bsy, on2, other);
    check($sformatf("%s duty0", name), 32'(on0), 32'(e_on0));
    if (e_busy >= 0) check($sformatf("%s busy", name), 32'(bsy), 32'(e_busy));
    check($sformatf("%s duty0_step100", name), 32'(on2), 32'(e_on2));
    check($sformatf("%s other_leds", name), 32'(other), 32'd0);
  endtask

  initial begin
    int on0, bsy, on2, other, bad;
    logic [N-1:0] prev;

    vecs[0] = '{10'h2AA, 1'b1};
    vecs[1] = '{10'h155, 1'b1};
    vecs[2] = '{10'h155, 1'b0};
    vecs[3] = '{10'h3FF, 1'b1};
    vecs[4] = '{10'h000, 1'b1};
    vecs[5] = '{10'h201, 1'b1};

    // Reset values while reset is held.
    #12;
    check("reset leds", 32'(leds), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset leds2", 32'(leds2), 32'd0);

    // Test 1: idle pattern keeps everything dark and not busy.
    apply_reset('0, 1'b1);
    bad = 0;
    for (int k = 0; k < 2048; k++) begin
      tick();
      if (leds != '0 || busy || leds2 != '0 || busy2) bad++;
    end
    check("idle samples active", 32'(bad), 32'd0);

    // Test 2 and 5: fade up, then fade down, both step sizes.
    apply_reset(10'h001, 1'b1);
    window("up0", 0, 256 - SYNC, 0, 10'h001);
    window("up1", 64, 256, 100, 10'h001);
    window("up2", 128, 256, 200, 10'h001);
    window("up3", 192, 256, 256, 10'h001);
    window("up4", 256, 0, 256, 10'h001);
    led_pattern = '0;
    window("dn0", 256, 256 - SYNC, 256, 10'h001);
    window("dn1", 191, 256, 155, 10'h001);
    window("dn2", 127, 256, 55, 10'h001);
    window("dn3", 63, 256, 0, 10'h001);
    window("dn4", 0, 0, 0, 10'h001);

    // Test 3: reversal at level 128, then toggle landing on a period_end cycle.
    apply_reset(10'h001, 1'b1);
    window("rv0", 0, 256 - SYNC, 0, 10'h001);
    window("rv1", 64, 256, 100, 10'h001);
    led_pattern = '0;
    window("rv2", 128, 256, 200, 10'h001);
    window("rv3", 64, 256, 100, 10'h001);
    on0 = 0; bsy = 0; on2 = 0; other = 0;
    measure(255 - SYNC, 10'h001, on0, bsy, on2, other);
    led_pattern = 10'h001;
    measure(1 + SYNC, 10'h001, on0, bsy, on2, other);
    check("rv4 duty0", 32'(on0), 32'd0);
    check("rv4 busy", 32'(bsy), 32'd1);
    check("rv4 duty0_step100", 32'(on2), 32'd0);
    window("rv5", 64, 256, 100, 10'h001);

    // Test 4: direct follow with fade disabled, exact output latency.
    apply_reset('0, 1'b0);
    repeat (8) tick();
    prev = '0;
    for (int v = 0; v < 6; v++) begin
      led_pattern = vecs[v].pat;
      repeat (LAT - 1) tick();
      check($sformatf("direct%0d leds_early", v), 32'(leds), 32'(prev));
      check($sformatf("direct%0d busy_early", v), 32'(busy), 32'(vecs[v].busy_mid));
      tick();
      check($sformatf("direct%0d leds", v), 32'(leds), 32'(vecs[v].pat));
      check($sformatf("direct%0d busy", v), 32'(busy), 32'd0);
      check($sformatf("direct%0d leds2", v), 32'(leds2), 32'(vecs[v].pat));
      prev = vecs[v].pat;
    end

    // Test 4b: fade_enable drops mid-ramp, then rises and fading resumes from full.
    apply_reset(10'h001, 1'b1);
    repeat (300) tick();
    fade_enable = 1'b0;
    repeat (LAT) tick();
    check("snap leds", 32'(leds), 32'h001);
    check("snap busy", 32'(busy), 32'd0);
    check("snap leds2", 32'(leds2), 32'h001);
    fade_enable = 1'b1;
    led_pattern = '0;
    repeat (512 - cyc) tick();
    window("resume0", 191, 256, 155, 10'h001);
    window("resume1", 127, 256, 55, 10'h001);

    // Test 6: asynchronous reset between clock edges mid-ramp.
    apply_reset(10'h3FF, 1'b1);
    repeat (600) tick();
    check("pre_reset leds", 32'(leds), 32'h3FF);
    check("pre_reset busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async leds", 32'(leds), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async leds2", 32'(leds2), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    window("all0", 0, 256 - SYNC, 0, 10'h3FF);
    window("all1", 64, 256, 100, 10'h3FF);
    window("all2", 128, 256, 200, 10'h3FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
